// File: rtl/tick_stim_gen.sv
`default_nettype none
// ============================================================================
// tick_stim_gen : ready/valid market-tick source (const/ramp/walk/spike)
// Revision      : 1.0
// ============================================================================
module tick_stim_gen #(
  parameter int          PRICE_W      = 8,
  parameter int          VOL_W        = 8,
  parameter int          CHANNELS     = 2,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          SPIKE_PERIOD = 8,
  parameter int          SPIKE_MAG    = 32,
  localparam int         CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [1:0]         cfg_mode,
  input  logic [15:0]        cfg_count,
  input  logic [PRICE_W-1:0] cfg_base,
  input  logic [PRICE_W-1:0] cfg_step,
  input  logic [VOL_W-1:0]   cfg_vol,
  output logic               tick_valid,
  input  logic               tick_ready,
  output logic [CW-1:0]      tick_chan,
  output logic [PRICE_W-1:0] tick_price,
  output logic [VOL_W-1:0]   tick_vol,
  output logic               busy,
  output logic               done
);

  localparam logic [15:0] c_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] c_TAPS = 16'hB400;
  localparam int          c_PMAX = (1 << PRICE_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [15:0]        tgt_q, tgt_d;
  logic [PRICE_W-1:0] step_q, step_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CW-1:0]      chan_q, chan_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [PRICE_W-1:0] price_q [CHANNELS];
  logic [PRICE_W-1:0] price_d [CHANNELS];

  logic [PRICE_W-1:0] w_cur_price;
  logic [PRICE_W-1:0] w_next_price;
  logic [PRICE_W-1:0] w_spike_price;
  logic [PRICE_W+1:0] w_walk_sum;
  logic [32:0]        w_spike_sum;
  logic [15:0]        w_cnt_inc;
  logic [15:0]        w_lfsr_adv;
  logic               w_spike;
  logic               w_hs;

  always_comb begin
    w_cur_price = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_q == CW'(i)) w_cur_price = price_q[i];
    end
  end

  assign w_cnt_inc  = cnt_q + 16'd1;
  assign w_lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? c_TAPS : 16'h0000);
  assign w_spike    = (mode_q == 2'd3) && ((w_cnt_inc % 16'(SPIKE_PERIOD)) == 16'd0);
  assign w_hs       = ena && tick_valid && tick_ready;

  // Walk sum is one bit wider than needed so the sign bit flags underflow.
  assign w_walk_sum  = {2'b00, w_cur_price} + {{(PRICE_W-2){lfsr_q[3]}}, lfsr_q[3:0]};
  assign w_spike_sum = {{(33-PRICE_W){1'b0}}, w_cur_price} + 33'(SPIKE_MAG);

  always_comb begin
    w_spike_price = w_spike_sum[PRICE_W-1:0];
    if (w_spike_sum > 33'(c_PMAX)) w_spike_price = PRICE_W'(c_PMAX);
  end

  always_comb begin
    w_next_price = w_cur_price;
    case (mode_q)
      2'd1, 2'd3: w_next_price = w_cur_price + step_q;
      2'd2: begin
        if (w_walk_sum[PRICE_W+1])  w_next_price = '0;
        else if (w_walk_sum[PRICE_W]) w_next_price = PRICE_W'(c_PMAX);
        else                          w_next_price = w_walk_sum[PRICE_W-1:0];
      end
      default: w_next_price = w_cur_price;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    vol_d   = vol_q;
    lfsr_d  = lfsr_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    price_d = price_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_start) begin
          state_d = S_RUN;
          mode_d  = cfg_mode;
          tgt_d   = cfg_count;
          step_d  = cfg_step;
          vol_d   = cfg_vol;
          lfsr_d  = c_SEED;
          chan_d  = '0;
          cnt_d   = '0;
          for (int i = 0; i < CHANNELS; i++) price_d[i] = cfg_base;
        end
      end
      S_RUN: begin
        if (w_hs) begin
          cnt_d  = w_cnt_inc;
          lfsr_d = w_lfsr_adv;
          chan_d = (chan_q == CW'(CHANNELS-1)) ? '0 : chan_q + CW'(1);
          for (int i = 0; i < CHANNELS; i++) begin
            if (chan_q == CW'(i)) price_d[i] = w_next_price;
          end
        end
        // A tick accepted in the same cycle as stop still counts.
        if (cfg_stop || (w_hs && (tgt_q != 16'd0) && (w_cnt_inc == tgt_q))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      tgt_q   <= 16'd0;
      step_q  <= '0;
      vol_q   <= '0;
      lfsr_q  <= c_SEED;
      chan_q  <= '0;
      cnt_q   <= 16'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) price_q[i] <= '0;
    end else if (ena) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      vol_q   <= vol_d;
      lfsr_q  <= lfsr_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      price_q <= price_d;
    end
  end

  assign tick_valid = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign tick_chan  = chan_q;
  assign tick_price = w_spike ? w_spike_price : w_cur_price;
  assign tick_vol   = w_spike ? '1 : (mode_q[1] ? lfsr_q[VOL_W-1:0] : vol_q);

endmodule
`default_nettype wire

// File: doc/tick_stim_gen.md
# tick_stim_gen

Parametrised, synthesizable market-tick stimulus generator for the NanoTrade core: emits a stream of (channel, price, volume) ticks over a ready/valid interface, in constant, ramp, LFSR random-walk or spike-injection mode. It replaces the fixed idle-input bench stimulus with an on-chip/in-bench traffic source usable for self-test of the anomaly/trade logic behind `tt_um_nanotrade`, generalised over price/volume width and channel count.

## Interface
- `PRICE_W`, 8: price width, 4..16.
- `VOL_W`, 8: volume width, 1..16.
- `CHANNELS`, 2: interleaved instrument channels, 1..4.
- `SEED`, 16'hACE1: LFSR reload value; 0 is replaced by 16'h0001.
- `SPIKE_PERIOD`, 8: every Nth emitted tick is a spike in mode 3, N ≥ 2.
- `SPIKE_MAG`, 32: added to price on spike ticks.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ena` in 1: global enable; low freezes all state and outputs.
- `cfg_start` in 1: start pulse, sampled only in IDLE/DONE.
- `cfg_stop` in 1: abort request.
- `cfg_mode` in 2: 0 const, 1 ramp, 2 random walk, 3 ramp+spike.
- `cfg_count` in 16: ticks to emit; 0 = run until stop.
- `cfg_base` in PRICE_W: starting price for every channel.
- `cfg_step` in PRICE_W: ramp increment.
- `cfg_vol` in VOL_W: volume in modes 0/1.
- `tick_valid` out 1, `tick_ready` in 1: handshake.
- `tick_chan` out clog2(CHANNELS) (min 1): channel tag.
- `tick_price` out PRICE_W, `tick_vol` out VOL_W.
- `busy` out 1: RUN state. `done` out 1: one-cycle completion pulse.

## Operation
- States IDLE, RUN, DONE. Reset → IDLE: `tick_valid`=0, `busy`=0, `done`=0, `tick_chan`=0, `tick_price`=0, `tick_vol`=0, all channel prices 0, LFSR=SEED, tick counter 0.
- IDLE/DONE + `cfg_start` → RUN: latch mode/count/base/step/vol; every channel price = `cfg_base`; LFSR reloaded; chan pointer 0; counter 0. `cfg_start` in RUN ignored.
- RUN: present tick for current channel; on handshake (valid && ready): counter++, update that channel's price, advance LFSR, chan pointer → (ptr+1) mod CHANNELS.
- Emitted price = stored channel price (pre-update). Updates:
  - mode 0: unchanged.
  - mode 1: +step, wraps mod 2^PRICE_W.
  - mode 2: + signed LFSR[3:0] (−8..+7), saturating to [0, 2^PRICE_W−1].
  - mode 3: as mode 1; additionally when (counter+1) mod SPIKE_PERIOD == 0, emitted price = stored + SPIKE_MAG saturated at max, volume = all-ones; stored price unaffected by spike.
- Volume: modes 0/1 `cfg_vol`; modes 2/3 LFSR[VOL_W−1:0] (non-spike).
- LFSR: 16-bit Galois, taps 16'hB400, shift right; advances only on handshake.
- Completion: handshake of tick number `cfg_count` (count≠0) → DONE, `done` pulsed.
- `cfg_stop` in RUN: if no handshake that cycle, drop valid next cycle → DONE with `done` pulse; if handshake same cycle, that tick counts, then DONE. Stop in IDLE/DONE ignored.
- DONE holds until `cfg_start`; `done` is high only on entry cycle.
- `ena`=0: no state, counter, LFSR or output changes; handshake not recognised.

## Timing
- Start→first `tick_valid`: 1 cycle (valid high the cycle after `cfg_start` sampled).
- Throughput: 1 tick/cycle with `tick_ready` held high; no bubbles between channels.
- While valid && !ready: chan/price/vol stable, valid stays high (AXI-style; valid never depends on ready).
- Final handshake at edge N → `tick_valid`=0, `busy`=0, `done`=1 during cycle N+1.
- `rst_n` low mid-run: next edge returns to reset values regardless of `ena`; no `done` pulse.
- Counter wraps are irrelevant for count≠0; for count=0 counter wraps mod 2^16 silently (spike cadence follows wrapped counter).

## Test plan
- Ramp, CHANNELS=2, base 100, step 3, count 6, ready=1 → (ch,price) 0/100, 1/100, 0/103, 1/103, 0/106, 1/106 on consecutive cycles; `done` one cycle after last; vol = `cfg_vol`.
- Wrap, CHANNELS=1, base 254, step 1, count 4 → 254, 255, 0, 1.
- Backpressure: ramp, ready low for 3 cycles mid-stream → valid and data held constant those cycles; no tick lost or duplicated; total 6 ticks.
- Random walk, base 2 and base 253, PRICE_W=8, 200 ticks → prices never leave [0,255]; sequence matches reference LFSR model seeded 16'hACE1.
- Spike, SPIKE_PERIOD 4, SPIKE_MAG 32, base 240, step 1, CHANNELS=1 → ticks 4,8 price 255 saturated (243+32, 247+32), vol all-ones; tick 5 = 244.
- Stop/reset: count 0, assert `cfg_stop` after 5 ticks → exactly 5 accepted, `done` pulse; repeat with `rst_n` low mid-run → all outputs reset values next cycle, no `done`; `ena`=0 for 2 cycles → outputs frozen.
